// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SPI-mode SD card target: command decode, R1 replies, single-block read/write
module sd_spi_responder #(
  parameter int ADDR_W     = 24,
  parameter int NCR_BYTES  = 1,
  parameter int INIT_POLLS = 2,
  parameter int BUSY_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              card_idle,
  output logic [3:0]        status
);

  typedef enum logic [3:0] {
    HUNT, CMD_RX, RESP_GAP, RESP_TX,
    RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_DRESP, WR_BUSY
  } state_t;

  typedef enum logic [1:0] {ACT_NONE, ACT_READ, ACT_WRITE} act_t;

  localparam logic [9:0] NCR_LAST  = 10'(NCR_BYTES - 1);
  localparam logic [9:0] BUSY_LAST = 10'(BUSY_BYTES - 1);
  localparam logic [7:0] POLLS     = 8'(INIT_POLLS);

  logic              cs_m, cs_s, sclk_m, sclk_s, sclk_d, mosi_m, mosi_s;
  state_t            state_q, state_d;
  act_t              act_q, act_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [9:0]        byte_cnt_q, byte_cnt_d;
  logic [46:0]       cmd_sh_q, cmd_sh_d;
  logic [7:0]        rx_q, rx_d, tx_q, tx_d, r1_q, r1_d, rd_buf_q, rd_buf_d;
  logic [7:0]        acmd_cnt_q, acmd_cnt_d;
  logic [ADDR_W-1:0] arg_q, arg_d, mem_addr_d;
  logic              miso_d, mem_rd_d, mem_wr_d, rd_pend_q, idle_d, app_q, app_d;
  logic [7:0]        mem_wdata_d;
  logic              sclk_rise, sclk_fall, byte_end;
  logic [47:0]       frame;
  logic [7:0]        byte_in;
  logic [5:0]        cmd;
  logic [7:0]        r1_v;
  logic              unused_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_m   <= 1'b1;
      cs_s   <= 1'b1;
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      mosi_m <= 1'b1;
      mosi_s <= 1'b1;
    end else begin
      cs_m   <= cs;
      cs_s   <= cs_m;
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  assign sclk_rise    = sclk_s & ~sclk_d;
  assign sclk_fall    = ~sclk_s & sclk_d;
  assign byte_end     = sclk_rise && (bit_cnt_q[2:0] == 3'd7);
  assign frame        = {cmd_sh_q, mosi_s};
  assign byte_in      = {rx_q[6:0], mosi_s};
  assign cmd          = frame[45:40];
  assign status       = state_q;
  assign unused_frame = ^frame;

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    cmd_sh_d    = cmd_sh_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    r1_d        = r1_q;
    rd_buf_d    = rd_pend_q ? mem_rdata : rd_buf_q;
    acmd_cnt_d  = acmd_cnt_q;
    arg_d       = arg_q;
    idle_d      = card_idle;
    app_d       = app_q;
    miso_d      = miso;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    r1_v        = {5'b0, 1'b1, 1'b0, card_idle};
    if (cs_s) begin
      state_d  = HUNT;
      miso_d   = 1'b1;
      tx_d     = 8'hFF;
      cmd_sh_d = '1;
    end else begin
      // Bytes are loaded into tx on the last rise of the previous byte and shifted out on falls.
      if (sclk_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b1};
      end
      if (sclk_rise) begin
        rx_d      = byte_in;
        bit_cnt_d = bit_cnt_q + 6'd1;
        case (state_q)
          HUNT: begin
            cmd_sh_d = frame[46:0];
            if (!cmd_sh_q[0] && mosi_s) begin
              state_d   = CMD_RX;
              bit_cnt_d = 6'd2;
            end
          end
          CMD_RX: begin
            cmd_sh_d = frame[46:0];
            if (bit_cnt_q == 6'd47) begin
              arg_d = frame[8 +: ADDR_W];
              app_d = 1'b0;
              act_d = ACT_NONE;
              case (cmd)
                6'd0: begin
                  r1_v       = 8'h01;
                  idle_d     = 1'b1;
                  acmd_cnt_d = 8'd0;
                end
                6'd55: begin
                  r1_v  = {7'b0, card_idle};
                  app_d = 1'b1;
                end
                6'd17, 6'd24: begin
                  if (card_idle) begin
                    r1_v = 8'h05;
                  end else begin
                    r1_v  = 8'h00;
                    act_d = (cmd == 6'd17) ? ACT_READ : ACT_WRITE;
                  end
                end
                6'd41: begin
                  if (app_q) begin
                    if (!card_idle) begin
                      r1_v = 8'h00;
                    end else begin
                      acmd_cnt_d = acmd_cnt_q + 8'd1;
                      if (acmd_cnt_q + 8'd1 >= POLLS) begin
                        idle_d = 1'b0;
                        r1_v   = 8'h00;
                      end else begin
                        r1_v = 8'h01;
                      end
                    end
                  end
                end
                default: ;
              endcase
              r1_d       = r1_v;
              tx_d       = 8'hFF;
              bit_cnt_d  = 6'd0;
              byte_cnt_d = 10'd0;
              state_d    = RESP_GAP;
            end
          end
          RESP_GAP: begin
            if (byte_end) begin
              if (byte_cnt_q == NCR_LAST) begin
                tx_d    = r1_q;
                state_d = RESP_TX;
              end else begin
                tx_d       = 8'hFF;
                byte_cnt_d = byte_cnt_q + 10'd1;
              end
            end
          end
          RESP_TX: begin
            if (byte_end) begin
              tx_d       = 8'hFF;
              byte_cnt_d = 10'd0;
              case (act_q)
                ACT_READ:  state_d = RD_GAP;
                ACT_WRITE: begin
                  state_d = WR_TOKEN;
                  rx_d    = 8'hFF;
                end
                default: begin
                  state_d  = HUNT;
                  cmd_sh_d = '1;
                end
              endcase
            end
          end
          RD_GAP: begin
            if (byte_end) begin
              tx_d       = 8'hFE;
              state_d    = RD_TOKEN;
              mem_rd_d   = 1'b1;
              mem_addr_d = arg_q;
            end
          end
          RD_TOKEN: begin
            if (byte_end) begin
              tx_d       = rd_buf_q;
              byte_cnt_d = 10'd0;
              state_d    = RD_DATA;
              mem_rd_d   = 1'b1;
              mem_addr_d = arg_q + ADDR_W'(1);
            end
          end
          RD_DATA: begin
            // The read for byte n+2 is issued while byte n+1 is loaded, one byte ahead of need.
            if (byte_end) begin
              if (byte_cnt_q == 10'd511) begin
                tx_d       = 8'hFF;
                byte_cnt_d = 10'd0;
                state_d    = RD_CRC;
              end else begin
                tx_d       = rd_buf_q;
                byte_cnt_d = byte_cnt_q + 10'd1;
                if (byte_cnt_q < 10'd510) begin
                  mem_rd_d   = 1'b1;
                  mem_addr_d = arg_q + ADDR_W'(byte_cnt_q) + ADDR_W'(2);
                end
              end
            end
          end
          RD_CRC: begin
            if (byte_end) begin
              tx_d = 8'hFF;
              if (byte_cnt_q == 10'd1) begin
                state_d  = HUNT;
                cmd_sh_d = '1;
              end else begin
                byte_cnt_d = byte_cnt_q + 10'd1;
              end
            end
          end
          WR_TOKEN: begin
            if (byte_in == 8'hFE) begin
              state_d    = WR_DATA;
              bit_cnt_d  = 6'd0;
              byte_cnt_d = 10'd0;
            end
          end
          WR_DATA: begin
            if (byte_end) begin
              mem_wr_d    = 1'b1;
              mem_wdata_d = byte_in;
              mem_addr_d  = arg_q + ADDR_W'(byte_cnt_q);
              if (byte_cnt_q == 10'd511) begin
                byte_cnt_d = 10'd0;
                state_d    = WR_CRC;
              end else begin
                byte_cnt_d = byte_cnt_q + 10'd1;
              end
            end
          end
          WR_CRC: begin
            if (byte_end) begin
              if (byte_cnt_q == 10'd1) begin
                tx_d       = 8'h05;
                byte_cnt_d = 10'd0;
                state_d    = WR_DRESP;
              end else begin
                byte_cnt_d = byte_cnt_q + 10'd1;
              end
            end
          end
          WR_DRESP: begin
            if (byte_end) begin
              tx_d       = 8'h00;
              byte_cnt_d = 10'd0;
              state_d    = WR_BUSY;
            end
          end
          WR_BUSY: begin
            if (byte_end) begin
              if (byte_cnt_q == BUSY_LAST) begin
                tx_d     = 8'hFF;
                state_d  = HUNT;
                cmd_sh_d = '1;
              end else begin
                tx_d       = 8'h00;
                byte_cnt_d = byte_cnt_q + 10'd1;
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      act_q      <= ACT_NONE;
      bit_cnt_q  <= 6'd0;
      byte_cnt_q <= 10'd0;
      cmd_sh_q   <= '1;
      rx_q       <= 8'hFF;
      tx_q       <= 8'hFF;
      r1_q       <= 8'hFF;
      rd_buf_q   <= 8'h00;
      rd_pend_q  <= 1'b0;
      acmd_cnt_q <= 8'd0;
      arg_q      <= '0;
      card_idle  <= 1'b1;
      app_q      <= 1'b0;
      miso       <= 1'b1;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      cmd_sh_q   <= cmd_sh_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      r1_q       <= r1_d;
      rd_buf_q   <= rd_buf_d;
      rd_pend_q  <= mem_rd;
      acmd_cnt_q <= acmd_cnt_d;
      arg_q      <= arg_d;
      card_idle  <= idle_d;
      app_q      <= app_d;
      miso       <= miso_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - directed bench for sd_spi_responder acting as an SPI host
module tb_sd_spi_responder;

  localparam int ADDR_W = 24;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cs = 1'b1;
  logic              sclk = 1'b0;
  logic              mosi = 1'b1;
  logic              miso, mem_rd, mem_wr, card_idle;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic [7:0]        mem_wdata;
  logic [3:0]        status;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [7:0]        wr_data_log[$];

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [7:0]  r1;
    logic        idle;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  sd_spi_responder #(
    .ADDR_W(ADDR_W), .NCR_BYTES(1), .INIT_POLLS(2), .BUSY_BYTES(4)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .card_idle(card_idle), .status(status)
  );

  // Memory holds mem[i] = i[7:0]; writes are only logged.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem_addr[7:0];
      rd_log.push_back(mem_addr);
    end
    if (mem_wr) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] c, input logic [31:0] a,
                          output logic [7:0] r1, output int nfill);
    logic [7:0] rx;
    xfer({2'b01, c}, rx);
    xfer(a[31:24], rx);
    xfer(a[23:16], rx);
    xfer(a[15:8], rx);
    xfer(a[7:0], rx);
    xfer(8'h95, rx);
    r1 = 8'hFF;
    nfill = 0;
    for (int i = 0; i < 10; i++) begin
      xfer(8'hFF, rx);
      if (rx != 8'hFF) begin
        r1 = rx;
        break;
      end
      nfill++;
    end
  endtask

  task automatic poll_token(output logic [7:0] tok, output int nff);
    logic [7:0] rx;
    tok = 8'hFF;
    nff = 0;
    for (int i = 0; i < 8; i++) begin
      xfer(8'hFF, rx);
      if (rx != 8'hFF) begin
        tok = rx;
        break;
      end
      nff++;
    end
  endtask

  task automatic read_block(input logic [31:0] arg, input string tag);
    logic [7:0] r1, rx, tok, c1, c2;
    int nf, nff, bad, abad;
    rd_log.delete();
    send_cmd(6'd17, arg, r1, nf);
    check({tag, "_r1"}, r1, 32'h00);
    poll_token(tok, nff);
    check({tag, "_token"}, tok, 32'hFE);
    check({tag, "_token_gap"}, nff, 1);
    bad = 0;
    for (int n = 0; n < 512; n++) begin
      xfer(8'hFF, rx);
      if (rx != 8'((arg + n) & 32'hFF)) bad++;
    end
    check({tag, "_data_bad"}, bad, 0);
    xfer(8'hFF, c1);
    xfer(8'hFF, c2);
    check({tag, "_crc"}, {c1, c2}, 32'hFFFF);
    check({tag, "_rd_count"}, rd_log.size(), 512);
    abad = 0;
    foreach (rd_log[i]) if (rd_log[i] != ADDR_W'(arg + i)) abad++;
    check({tag, "_rd_addr_bad"}, abad, 0);
  endtask

  initial begin
    logic [7:0] r1, rx, tok;
    int nf, nff, bad;

    vecs[0] = '{6'd8,  32'h0000_01AA, 8'h05, 1'b1};
    vecs[1] = '{6'd0,  32'h0,         8'h01, 1'b1};
    vecs[2] = '{6'd55, 32'h0,         8'h01, 1'b1};
    vecs[3] = '{6'd41, 32'h4000_0000, 8'h01, 1'b1};
    vecs[4] = '{6'd55, 32'h0,         8'h01, 1'b1};
    vecs[5] = '{6'd41, 32'h4000_0000, 8'h00, 1'b0};
    vecs[6] = '{6'd8,  32'h0000_01AA, 8'h04, 1'b0};
    vecs[7] = '{6'd55, 32'h0,         8'h00, 1'b0};
    vecs[8] = '{6'd41, 32'h4000_0000, 8'h00, 1'b0};
    vecs[9] = '{6'd41, 32'h4000_0000, 8'h04, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_miso", miso, 1);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_card_idle", card_idle, 1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);

    // CMD17 while idle: illegal-style reply and no data token afterwards
    rd_log.delete();
    send_cmd(6'd17, 32'h0, r1, nf);
    check("t4_cmd17_idle_r1", r1, 32'h05);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      xfer(8'hFF, rx);
      if (rx != 8'hFF) bad++;
    end
    check("t4_no_token", bad, 0);
    check("t4_no_mem_rd", rd_log.size(), 0);

    foreach (vecs[i]) begin
      send_cmd(vecs[i].cmd, vecs[i].arg, r1, nf);
      check($sformatf("v%0d_cmd%0d_r1", i, vecs[i].cmd), r1, 32'(vecs[i].r1));
      check($sformatf("v%0d_ncr", i), nf, 1);
      check($sformatf("v%0d_idle", i), card_idle, 32'(vecs[i].idle));
      xfer(8'hFF, rx);
    end

    read_block(32'h200, "t2");

    wr_addr_log.delete();
    wr_data_log.delete();
    send_cmd(6'd24, 32'h400, r1, nf);
    check("t3_r1", r1, 32'h00);
    xfer(8'hFF, rx);
    xfer(8'hFE, rx);
    for (int n = 0; n < 512; n++) xfer(8'hA5 ^ n[7:0], rx);
    xfer(8'hFF, rx);
    xfer(8'hFF, rx);
    xfer(8'hFF, rx);
    check("t3_dresp", rx, 32'h05);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      xfer(8'hFF, rx);
      if (rx != 8'h00) bad++;
    end
    check("t3_busy_bad", bad, 0);
    xfer(8'hFF, rx);
    check("t3_after_busy", rx, 32'hFF);
    repeat (4) @(negedge clk);
    check("t3_wr_count", wr_addr_log.size(), 512);
    bad = 0;
    foreach (wr_addr_log[i])
      if (wr_addr_log[i] != ADDR_W'(32'h400 + i) || wr_data_log[i] != (8'hA5 ^ 8'(i))) bad++;
    check("t3_wr_bad", bad, 0);

    // Abort a read with cs while byte 100 (0x64, MSB 0) is on the wire
    send_cmd(6'd17, 32'h0, r1, nf);
    check("t5_r1", r1, 32'h00);
    poll_token(tok, nff);
    check("t5_token", tok, 32'hFE);
    for (int n = 0; n < 100; n++) xfer(8'hFF, rx);
    repeat (4) @(negedge clk);
    check("t5_miso_low", miso, 0);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_miso_cs_high", miso, 1);
    repeat (4) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    read_block(32'h0, "t5b");

    // Reset in the middle of a write, after 50 data bytes
    wr_addr_log.delete();
    wr_data_log.delete();
    send_cmd(6'd24, 32'h600, r1, nf);
    check("t6_r1", r1, 32'h00);
    xfer(8'hFF, rx);
    xfer(8'hFE, rx);
    for (int n = 0; n < 50; n++) xfer(8'(n), rx);
    mosi = 1'b0;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_idle_before", card_idle, 0);
    reset = 1'b1;
    #1;
    check("t6_rst_miso", miso, 1);
    check("t6_rst_mem_wr", mem_wr, 0);
    check("t6_rst_idle", card_idle, 1);
    check("t6_wr_count", wr_addr_log.size(), 50);
    mosi = 1'b1;
    cs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_wr_count_after", wr_addr_log.size(), 50);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(6'd17, 32'h0, r1, nf);
    check("t6_cmd17_r1", r1, 32'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
